// File: rtl/ones_count_arbiter.sv
// Round-robin arbiter that lends one serial ones-counter to NREQ requesters.
// Each granted session counts SESSION_LEN bits, then reports the count and an all-ones flag.
module ones_count_arbiter #(
  parameter int NREQ        = 4,
  parameter int SESSION_LEN = 8,
  parameter int CNT_W       = 2,
  parameter int ID_W        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  x_in,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic             done,
  output logic [ID_W-1:0]  done_id,
  output logic [CNT_W-1:0] cnt_out,
  output logic             y_out
);

  localparam int BC_W = $clog2(SESSION_LEN + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(SESSION_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPORT
  } state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_sel;
  logic [NREQ-1:0]  r_grant;
  logic [CNT_W-1:0] r_cnt;
  logic [BC_W-1:0]  r_bits;
  logic             r_busy;
  logic             r_done;
  logic [ID_W-1:0]  r_done_id;
  logic [CNT_W-1:0] r_cnt_out;
  logic             r_y;

  state_t           w_state_nx;
  logic [ID_W-1:0]  w_ptr_nx;
  logic [ID_W-1:0]  w_sel_nx;
  logic [NREQ-1:0]  w_grant_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [BC_W-1:0]  w_bits_nx;
  logic             w_done_nx;
  logic [ID_W-1:0]  w_done_id_nx;
  logic [CNT_W-1:0] w_cnt_out_nx;
  logic             w_y_nx;

  logic             w_found;
  logic             w_found_hi;
  logic [ID_W-1:0]  w_pick_lo;
  logic [ID_W-1:0]  w_pick_hi;
  logic [ID_W-1:0]  w_pick;
  logic [CNT_W-1:0] w_sum;

  // Wrapped search: lowest requester at or above the pointer wins, else lowest overall.
  always_comb begin
    w_found    = 1'b0;
    w_found_hi = 1'b0;
    w_pick_lo  = '0;
    w_pick_hi  = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (req[j] && !w_found) begin
        w_pick_lo = ID_W'(j);
        w_found   = 1'b1;
      end
      if (req[j] && (j >= 32'(r_ptr)) && !w_found_hi) begin
        w_pick_hi  = ID_W'(j);
        w_found_hi = 1'b1;
      end
    end
    w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
  end

  assign w_sum = r_cnt + CNT_W'(x_in[r_sel]);

  always_comb begin
    w_state_nx   = r_state;
    w_ptr_nx     = r_ptr;
    w_sel_nx     = r_sel;
    w_grant_nx   = r_grant;
    w_cnt_nx     = r_cnt;
    w_bits_nx    = r_bits;
    w_done_nx    = 1'b0;
    w_done_id_nx = r_done_id;
    w_cnt_out_nx = r_cnt_out;
    w_y_nx       = r_y;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nx = RUN;
          w_sel_nx   = w_pick;
          w_grant_nx = NREQ'(1) << w_pick;
          w_cnt_nx   = '0;
          w_bits_nx  = '0;
          w_ptr_nx   = (w_pick == ID_W'(NREQ - 1)) ? '0 : w_pick + ID_W'(1);
        end
      end
      RUN: begin
        if (!req[r_sel]) begin
          // Abort wins over a final bit on the same edge; results are left untouched.
          w_state_nx = IDLE;
          w_grant_nx = '0;
        end else begin
          w_cnt_nx  = w_sum;
          w_bits_nx = r_bits + BC_W'(1);
          if (r_bits == LAST_BIT) begin
            w_state_nx   = REPORT;
            w_grant_nx   = '0;
            w_done_nx    = 1'b1;
            w_done_id_nx = r_sel;
            w_cnt_out_nx = w_sum;
            w_y_nx       = &w_sum;
          end
        end
      end
      REPORT: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
        w_grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_sel     <= '0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_bits    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_cnt_out <= '0;
      r_y       <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_ptr     <= w_ptr_nx;
      r_sel     <= w_sel_nx;
      r_grant   <= w_grant_nx;
      r_cnt     <= w_cnt_nx;
      r_bits    <= w_bits_nx;
      r_busy    <= (w_state_nx != IDLE);
      r_done    <= w_done_nx;
      r_done_id <= w_done_id_nx;
      r_cnt_out <= w_cnt_out_nx;
      r_y       <= w_y_nx;
    end
  end

  assign grant   = r_grant;
  assign busy    = r_busy;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign cnt_out = r_cnt_out;
  assign y_out   = r_y;

endmodule

// File: tb/tb_ones_count_arbiter.sv
// Scoreboard bench for ones_count_arbiter: default instance plus a SESSION_LEN=1, CNT_W=1 instance.
module tb_ones_count_arbiter;

  typedef struct {
    int id;
    int cnt;
    int y;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] x_in;
  logic [3:0] grant;
  logic       busy;
  logic       done;
  logic [1:0] done_id;
  logic [1:0] cnt_out;
  logic       y_out;

  logic [3:0] req2;
  logic [3:0] x2;
  logic [3:0] grant2;
  logic       busy2;
  logic       done2;
  logic [1:0] done_id2;
  logic [0:0] cnt_out2;
  logic       y_out2;

  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  exp_t sb2[$];

  ones_count_arbiter #(.NREQ(4), .SESSION_LEN(8), .CNT_W(2), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .grant(grant), .busy(busy),
    .done(done), .done_id(done_id), .cnt_out(cnt_out), .y_out(y_out)
  );

  ones_count_arbiter #(.NREQ(4), .SESSION_LEN(1), .CNT_W(1), .ID_W(2)) dut1 (
    .clk(clk), .rst(rst), .req(req2), .x_in(x2), .grant(grant2), .busy(busy2),
    .done(done2), .done_id(done_id2), .cnt_out(cnt_out2), .y_out(y_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_id", int'(done_id), e.id);
        chk("cnt_out", int'(cnt_out), e.cnt);
        chk("y_out", int'(y_out), e.y);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && done2) begin
      if (sb2.size() == 0) chk("unexpected_done2", 1, 0);
      else begin
        exp_t e;
        e = sb2.pop_front();
        chk("done_id2", int'(done_id2), e.id);
        chk("cnt_out2", int'(cnt_out2), e.cnt);
        chk("y_out2", int'(y_out2), e.y);
      end
    end
  end

  task automatic wait_grant(input logic [3:0] exp_g, input string name);
    for (int c = 0; c < 20; c++) begin
      step();
      if (grant != 4'b0000) break;
    end
    chk(name, int'(grant), int'(exp_g));
  endtask

  task automatic run_lane(input int lane, input logic [7:0] bits, input logic [3:0] exp_g,
                          input int exp_cnt, input int exp_y, input bit rnd_others);
    exp_t e;
    e.id = lane; e.cnt = exp_cnt; e.y = exp_y;
    wait_grant(exp_g, "first_grant");
    sb.push_back(e);
    for (int k = 0; k < 8; k++) begin
      if (rnd_others) x_in = 4'($urandom);
      x_in[lane] = bits[k];
      chk("grant_held", int'(grant), int'(exp_g));
      step();
    end
    chk("grant_cleared", int'(grant), 0);
    chk("busy_report", int'(busy), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_done_id"}, int'(done_id), 0);
    chk({tag, "_cnt_out"}, int'(cnt_out), 0);
    chk({tag, "_y_out"}, int'(y_out), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b0;
    req  = '0;
    x_in = '0;
    req2 = '0;
    x2   = '0;
    #1;
    check_zero("rst0");
    step();
    rst = 1'b1;

    // Lane 0: three ones -> count 3, all-ones flag set
    req = 4'b0001;
    run_lane(0, 8'b0000_0111, 4'b0001, 3, 1, 1'b0);
    req = '0;
    step();

    // Lane 0: five ones wrap to 1; other lanes' data toggles randomly
    req = 4'b0001;
    run_lane(0, 8'b0001_1111, 4'b0001, 1, 0, 1'b1);
    req = '0;
    x_in = '0;
    step();

    // Abort: lane 1 drops request after three bits; lane 2 follows after one idle cycle
    req  = 4'b0110;
    x_in = 4'b0110;
    wait_grant(4'b0010, "abort_grant1");
    repeat (3) step();
    req = 4'b0100;
    step();
    chk("abort_grant", int'(grant), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_cnt_hold", int'(cnt_out), 1);
    chk("abort_y_hold", int'(y_out), 0);
    step();
    chk("after_abort_grant", int'(grant), 4'b0100);

    // Asynchronous reset in the middle of lane 2's session
    repeat (3) step();
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst  = 1'b1;
    req  = 4'b1001;
    x_in = 4'b1111;
    run_lane(0, 8'hFF, 4'b0001, 0, 0, 1'b0);
    req = '0;
    step();

    // Fairness: all lanes request continuously with ones on every lane
    rst = 1'b0;
    step();
    rst = 1'b1;
    begin
      logic [3:0] exp_g[5];
      logic [3:0] prev_g;
      int n_gr, n_done, last;
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
      for (int i = 0; i < 5; i++) begin
        exp_t e;
        e.id = i % 4; e.cnt = 0; e.y = 0;
        sb.push_back(e);
      end
      n_gr = 0; n_done = 0; last = 0; prev_g = '0;
      req  = 4'b1111;
      x_in = 4'b1111;
      for (int c = 0; c < 80 && n_done < 5; c++) begin
        step();
        if (grant != 4'b0000 && prev_g == 4'b0000) begin
          if (n_gr < 5) chk("rr_grant", int'(grant), int'(exp_g[n_gr]));
          n_gr++;
        end
        prev_g = grant;
        if (done) begin
          if (n_done > 0) chk("done_spacing", c - last, 10);
          last = c;
          n_done++;
        end
      end
      req = '0;
      chk("rr_done_count", n_done, 5);
      chk("rr_grant_count", n_gr, 5);
    end
    repeat (2) step();

    // Single-bit sessions with a 1-bit counter
    begin
      exp_t e;
      e.id = 0; e.cnt = 1; e.y = 1;
      sb2.push_back(e);
      req2 = 4'b0001;
      x2   = 4'b0001;
      for (int c = 0; c < 20; c++) begin
        step();
        if (grant2 != 4'b0000) break;
      end
      chk("s1_grant_a", int'(grant2), 1);
      step();
      chk("s1_done_a", int'(done2), 1);
      req2 = '0;
      repeat (2) step();
      e.cnt = 0; e.y = 0;
      sb2.push_back(e);
      req2 = 4'b0001;
      x2   = 4'b0000;
      for (int c = 0; c < 20; c++) begin
        step();
        if (grant2 != 4'b0000) break;
      end
      chk("s1_grant_b", int'(grant2), 1);
      step();
      chk("s1_done_b", int'(done2), 1);
      req2 = '0;
    end

    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    chk("sb2_drained", sb2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
